// File: rtl/gf_alu_serial_ctrl_if.sv
// gf_alu_serial_ctrl_if
//   Command/result handshake bundle for gf_alu_serial_ctrl.
//   Command: cmd_valid/cmd_ready, cmd_op[2:0], cmd_x/cmd_y[WIDTH].
//   Result : res_valid/res_ready, res_data[WIDTH], res_carry, res_ovf, res_err
//            (+ res_zero when GF_ALU_CTRL_ZFLAG_EN is defined).
//   master: command producer / result consumer; slave: the controller.
interface gf_alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_x;
    logic [WIDTH-1:0] cmd_y;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_ovf;
    logic             res_err;
`ifdef GF_ALU_CTRL_ZFLAG_EN
    logic             res_zero;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_ovf, res_err
`ifdef GF_ALU_CTRL_ZFLAG_EN
        , input res_zero
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_ovf, res_err
`ifdef GF_ALU_CTRL_ZFLAG_EN
        , output res_zero
`endif
    );
endinterface

// File: rtl/gf_alu_serial_ctrl.sv
// gf_alu_serial_ctrl
//   Word-level sequencer for the 1-bit ALU slice. Latches one command, feeds
//   operands LSB-first into the slice, closes the carry loop around the slice
//   latency (arith ops, one bit per ALU_LAT+1 cycles) or streams bits
//   back-to-back (logic ops), and returns the reassembled word.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   bus (slave)          command/result handshake (gf_alu_serial_ctrl_if)
//   alu_x/alu_y          serial operand bits
//   alu_carry_in/alu_end carry into current bit / MSB marker
//   alu_cmpl_x/y, alu_op_xor/and/arith  slice control lines
//   alu_sum/alu_carry_out/alu_overflow  slice results (ALU_LAT cycles later)
// Optional: GF_ALU_CTRL_ZFLAG_EN adds bus.res_zero.
module gf_alu_serial_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gf_alu_serial_ctrl_if.slave  bus,
    output logic                 alu_x,
    output logic                 alu_y,
    output logic                 alu_carry_in,
    output logic                 alu_end,
    output logic                 alu_cmpl_x,
    output logic                 alu_cmpl_y,
    output logic                 alu_op_xor,
    output logic                 alu_op_and,
    output logic                 alu_op_arith,
    input  logic                 alu_sum,
    input  logic                 alu_carry_out,
    input  logic                 alu_overflow
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LW = $clog2(ALU_LAT + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);
    localparam logic [LW-1:0] WAIT_INIT = LW'(ALU_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, y_q, res_data_q;
    logic             arith_q, and_q, xor_q, cmpl_x_q, cmpl_y_q;
    logic             carry_q, res_carry_q, res_ovf_q, res_err_q;
    logic [IW-1:0]    bit_idx_q;
    logic [LW-1:0]    wait_cnt_q;
    // Bit-index delay line for pipelined logic ops: stage ALU_LAT-1 holds the
    // index whose slice result is on alu_sum this cycle.
    logic [ALU_LAT-1:0] dl_v_q;
    logic [IW-1:0]      dl_idx_q [ALU_LAT];

    logic dec_legal, dec_arith, dec_and, dec_xor, dec_cx, dec_cy, dec_cin;
    logic last_bit, ctl_active, cap_logic;

    always_comb begin
        dec_legal = 1'b1;
        dec_arith = 1'b0;
        dec_and   = 1'b0;
        dec_xor   = 1'b0;
        dec_cx    = 1'b0;
        dec_cy    = 1'b0;
        dec_cin   = 1'b0;
        case (bus.cmd_op)
            3'b000:  dec_arith = 1'b1;
            3'b001:  begin dec_arith = 1'b1; dec_cy = 1'b1; dec_cin = 1'b1; end
            3'b010:  begin dec_arith = 1'b1; dec_cx = 1'b1; dec_cin = 1'b1; end
            3'b011:  dec_and = 1'b1;
            3'b100:  dec_xor = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        alu_x        = 1'b0;
        alu_y        = 1'b0;
        alu_carry_in = 1'b0;
        alu_end      = 1'b0;
        last_bit     = (bit_idx_q == LAST_IDX);
        cap_logic    = dl_v_q[ALU_LAT-1];
        ctl_active   = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN);
        alu_cmpl_x   = ctl_active & cmpl_x_q;
        alu_cmpl_y   = ctl_active & cmpl_y_q;
        alu_op_xor   = ctl_active & xor_q;
        alu_op_and   = ctl_active & and_q;
        alu_op_arith = ctl_active & arith_q;
        bus.cmd_ready = (state_q == S_IDLE);
        bus.res_valid = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) state_d = dec_legal ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                alu_x        = x_q[bit_idx_q];
                alu_y        = y_q[bit_idx_q];
                alu_carry_in = carry_q;
                alu_end      = last_bit;
                if (arith_q)       state_d = S_WAIT;
                else if (last_bit) state_d = S_DRAIN;
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) state_d = last_bit ? S_DONE : S_ISSUE;
            end
            S_DRAIN: begin
                if (cap_logic && dl_idx_q[ALU_LAT-1] == LAST_IDX) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            res_data_q  <= '0;
            arith_q     <= 1'b0;
            and_q       <= 1'b0;
            xor_q       <= 1'b0;
            cmpl_x_q    <= 1'b0;
            cmpl_y_q    <= 1'b0;
            carry_q     <= 1'b0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_err_q   <= 1'b0;
            bit_idx_q   <= '0;
            wait_cnt_q  <= '0;
            dl_v_q      <= '0;
            for (int unsigned k = 0; k < ALU_LAT; k++) dl_idx_q[k] <= '0;
        end else begin
            dl_v_q[0]   <= (state_q == S_ISSUE) && !arith_q;
            dl_idx_q[0] <= bit_idx_q;
            for (int unsigned k = ALU_LAT - 1; k > 0; k--) begin
                dl_v_q[k]   <= dl_v_q[k-1];
                dl_idx_q[k] <= dl_idx_q[k-1];
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        x_q         <= bus.cmd_x;
                        y_q         <= bus.cmd_y;
                        arith_q     <= dec_arith;
                        and_q       <= dec_and;
                        xor_q       <= dec_xor;
                        cmpl_x_q    <= dec_cx;
                        cmpl_y_q    <= dec_cy;
                        carry_q     <= dec_cin;
                        bit_idx_q   <= '0;
                        res_data_q  <= '0;
                        res_carry_q <= 1'b0;
                        res_ovf_q   <= 1'b0;
                        res_err_q   <= !dec_legal;
                    end
                end
                S_ISSUE: begin
                    if (arith_q) wait_cnt_q <= WAIT_INIT;
                    else         bit_idx_q  <= bit_idx_q + IW'(1);
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        res_data_q[bit_idx_q] <= alu_sum;
                        carry_q               <= alu_carry_out;
                        if (last_bit) begin
                            res_carry_q <= alu_carry_out;
                            res_ovf_q   <= alu_overflow;
                        end else begin
                            bit_idx_q <= bit_idx_q + IW'(1);
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - LW'(1);
                    end
                end
                default: ;
            endcase
            // Only logic ops load the delay line, so this never collides with
            // the arith capture above or the clear on accept.
            if (cap_logic) res_data_q[dl_idx_q[ALU_LAT-1]] <= alu_sum;
        end
    end

    always_comb begin
        bus.res_data  = res_data_q;
        bus.res_carry = res_carry_q;
        bus.res_ovf   = res_ovf_q;
        bus.res_err   = res_err_q;
`ifdef GF_ALU_CTRL_ZFLAG_EN
        bus.res_zero  = (state_q == S_DONE) && !res_err_q && (res_data_q == '0);
`endif
    end
endmodule

// File: tb/tb_gf_alu_serial_ctrl.sv
// tb_gf_alu_serial_ctrl
//   Drives gf_alu_serial_ctrl with directed and random commands against a
//   behavioural slice (ALU_LAT-deep pipeline) and a word-level result model.
module tb_gf_alu_serial_ctrl;
    localparam int W = 8;
    localparam int L = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gf_alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    logic alu_x, alu_y, alu_carry_in, alu_end, alu_cmpl_x, alu_cmpl_y;
    logic alu_op_xor, alu_op_and, alu_op_arith;
    logic alu_sum, alu_carry_out, alu_overflow;

    gf_alu_serial_ctrl #(.WIDTH(W), .ALU_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_x(alu_x), .alu_y(alu_y), .alu_carry_in(alu_carry_in), .alu_end(alu_end),
        .alu_cmpl_x(alu_cmpl_x), .alu_cmpl_y(alu_cmpl_y),
        .alu_op_xor(alu_op_xor), .alu_op_and(alu_op_and), .alu_op_arith(alu_op_arith),
        .alu_sum(alu_sum), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow)
    );

    // Behavioural 1-bit slice: result of a bit driven in cycle c shows in cycle c+L.
    // It is deliberately never reset, so stale results survive a controller reset.
    logic sa, sb, s_sum, s_co, s_ov;
    always_comb begin
        sa = alu_x ^ alu_cmpl_x;
        sb = alu_y ^ alu_cmpl_y;
        s_sum = 1'b0; s_co = 1'b0; s_ov = 1'b0;
        if (alu_op_arith) begin
            s_sum = sa ^ sb ^ alu_carry_in;
            s_co  = (sa & sb) | (alu_carry_in & (sa ^ sb));
            s_ov  = alu_carry_in ^ s_co;
        end else if (alu_op_xor) s_sum = sa ^ sb;
        else if (alu_op_and)     s_sum = sa & sb;
    end
    logic [L-1:0] p_sum = '0, p_co = '0, p_ov = '0;
    always @(posedge clk) begin
        p_sum <= {p_sum[L-2:0], s_sum};
        p_co  <= {p_co[L-2:0], s_co};
        p_ov  <= {p_ov[L-2:0], s_ov};
    end
    assign alu_sum       = p_sum[L-1];
    assign alu_carry_out = p_co[L-1];
    assign alu_overflow  = p_ov[L-1];

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_d;
    logic exp_c, exp_v, exp_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic [W-1:0] d, output logic c, output logic v, output logic e);
        logic [W:0] s;
        logic [W-1:0] a, b;
        logic ci;
        a = x; b = y; ci = 1'b0; d = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (op)
            3'd0: ;
            3'd1: begin b = ~y; ci = 1'b1; end
            3'd2: begin a = ~x; ci = 1'b1; end
            3'd3: d = x & y;
            3'd4: d = x ^ y;
            default: e = 1'b1;
        endcase
        if (op <= 3'd2) begin
            s = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            d = s[W-1:0];
            c = s[W];
            v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
    endtask

    task automatic consume(input int hold);
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op = 3'd0;
            @(posedge clk); #1;
            chk("hold_res", {bus.res_valid, bus.res_err, bus.res_ovf, bus.res_carry, bus.res_data},
                {1'b1, exp_e, exp_v, exp_c, exp_d});
            chk("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("release_cmd_ready", bus.cmd_ready, 1);
        chk("release_res_valid", bus.res_valid, 0);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
        int n, lat, end_cnt, end_pos, x_ones, y_ones, ctl_cnt, exp_lat, step;
        logic [W-1:0] rx, ry;
        bit legal, arith;
        ref_model(op, x, y, exp_d, exp_c, exp_v, exp_e);
        legal = (op <= 3'd4);
        arith = (op <= 3'd2);
        exp_lat = !legal ? 1 : (arith ? W * (L + 1) + 1 : W + L + 1);
        step = arith ? L + 1 : 1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("cmd_ready_before_accept", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_x = W'($urandom); bus.cmd_y = W'($urandom);
        lat = 0; end_cnt = 0; end_pos = 0; x_ones = 0; y_ones = 0; ctl_cnt = 0;
        rx = '0; ry = '0;
        for (int c = 1; c <= 300; c++) begin
            if (alu_end) begin end_cnt++; end_pos = c; end
            if (alu_x) x_ones++;
            if (alu_y) y_ones++;
            if (alu_op_xor | alu_op_and | alu_op_arith | alu_cmpl_x | alu_cmpl_y) ctl_cnt++;
            if ((c - 1) % step == 0 && (c - 1) / step < W) begin
                rx[(c - 1) / step] = alu_x;
                ry[(c - 1) / step] = alu_y;
            end
            if (bus.res_valid === 1'b1) begin lat = c; break; end
            @(posedge clk); #1;
        end
        chk("latency", lat, exp_lat);
        chk("res_data", bus.res_data, exp_d);
        chk("res_carry", bus.res_carry, exp_c);
        chk("res_ovf", bus.res_ovf, exp_v);
        chk("res_err", bus.res_err, exp_e);
        chk("alu_end_count", end_cnt, legal ? 1 : 0);
        chk("alu_end_pos", end_pos, legal ? 1 + (W - 1) * step : 0);
        chk("alu_x_ones", x_ones, legal ? $countones(x) : 0);
        chk("alu_y_ones", y_ones, legal ? $countones(y) : 0);
        chk("alu_x_stream", rx, legal ? x : '0);
        chk("alu_y_stream", ry, legal ? y : '0);
        chk("ctl_cycles", ctl_cnt, legal ? exp_lat - 1 : 0);
`ifdef GF_ALU_CTRL_ZFLAG_EN
        chk("res_zero", bus.res_zero, !exp_e && (exp_d == '0));
`endif
        consume(hold);
    endtask

    task automatic chk_reset_state(input string tag);
        chk(tag, {bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_carry, bus.res_ovf, bus.res_err,
                  alu_x, alu_y, alu_carry_in, alu_end, alu_cmpl_x, alu_cmpl_y,
                  alu_op_xor, alu_op_and, alu_op_arith},
            {1'b1, 1'b0, {W{1'b0}}, 3'b000, 9'b0});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0; bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset_state");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_cmd(3'd0, 8'h7F, 8'h01, 10);   // ADD overflow, long hold in DONE
        do_cmd(3'd0, 8'hFF, 8'h01, 0);    // ADD carry out
        do_cmd(3'd1, 8'h05, 8'h07, 0);    // SUB
        do_cmd(3'd2, 8'h05, 8'h07, 1);    // RSUB
        do_cmd(3'd3, 8'hF0, 8'h3C, 0);    // AND
        do_cmd(3'd4, 8'hF0, 8'h3C, 2);    // XOR
        do_cmd(3'd6, 8'hA5, 8'h5A, 0);    // illegal

        // Reset while bit 3 is waiting on the slice: bit 3 issues in cycle 19,
        // its wait spans cycles 20..24.
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_x = 8'h6B; bus.cmd_y = 8'h3D;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("midop_in_wait", {alu_op_arith, alu_x, alu_end}, 3'b100);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midop_reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_cmd(3'd4, 8'hAA, 8'h55, 0);

        for (int i = 0; i < 12; i++)
            do_cmd(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), $urandom_range(0, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gf_alu_serial_ctrl.md
Name: gf_alu_serial_ctrl

Overview:
- Word-level sequencer for the 1-bit gate-level ALU slice.
- Accepts one WIDTH-bit command: operands plus opcode.
- Feeds the operands LSB-first into the slice, drives its control lines and closes the carry loop around the slice's pipeline latency.
- Reassembles the Sum bitstream into a result word and returns it with carry and overflow flags over a valid/ready handshake.

Parameters:
- WIDTH, 8: operand/result width in bits (2..32).
- ALU_LAT, 5: slice latency, cycles from driving a bit on alu_* outputs to the matching alu_sum/alu_carry_out/alu_overflow (>=1).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, accepts command
- cmd_op  in  3  000 ADD, 001 SUB (X-Y), 010 RSUB (Y-X), 011 AND, 100 XOR; 101-111 illegal
- cmd_x  in  WIDTH  operand X
- cmd_y  in  WIDTH  operand Y
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  WIDTH  result word
- res_carry  out  1  final carry (arith ops), 0 otherwise
- res_ovf  out  1  signed overflow (arith ops), 0 otherwise
- res_err  out  1  illegal opcode flag
- alu_x, alu_y  out  1  serial operand bits
- alu_carry_in  out  1  carry into current bit
- alu_end  out  1  high with the MSB bit
- alu_cmpl_x, alu_cmpl_y  out  1  operand inversion
- alu_op_xor, alu_op_and, alu_op_arith  out  1  slice operation select
- alu_sum, alu_carry_out, alu_overflow  in  1  slice results

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, cmd_ready=1, res_valid=0.
  - res_data/res_carry/res_ovf/res_err=0.
  - All alu_* outputs 0, bit index 0.
- Reset mid-operation abandons the command and the result is discarded. Slice outputs arriving after reset are ignored until the next accepted command.
- Accept: cmd_valid&&cmd_ready on a clk edge latches op/x/y, deasserts cmd_ready and enters ISSUE.
- Illegal op: skip the slice, go directly to DONE with res_data=0, res_err=1, res_carry=res_ovf=0. res_valid rises the cycle after accept.
- Op decode, held constant for the whole command:
  - ADD: arith=1.
  - SUB: arith=1, cmpl_y=1, initial carry 1.
  - RSUB: arith=1, cmpl_x=1, initial carry 1.
  - AND: and=1.
  - XOR: xor=1.
- Arithmetic ops, ISSUE/WAIT loop with one bit per ALU_LAT+1 cycles:
  - ISSUE drives bit i for exactly one cycle.
  - alu_carry_in: initial carry for i=0, otherwise the registered alu_carry_out captured from bit i-1.
  - WAIT counts ALU_LAT cycles, then captures alu_sum into res_data[i] and alu_carry_out into the carry register.
  - Then i+1 -> ISSUE, or DONE after i=WIDTH-1.
  - On bit WIDTH-1: alu_end=1, and alu_carry_out/alu_overflow are captured into res_carry/res_ovf.
  - Latency accept->res_valid = WIDTH*(ALU_LAT+1)+1 cycles.
- Logic ops, pipelined:
  - ISSUE drives one bit per cycle for WIDTH consecutive cycles, alu_carry_in=0, alu_end on the MSB.
  - DRAIN captures alu_sum ALU_LAT cycles after each issue via a bit-index delay line.
  - Latency = WIDTH+ALU_LAT+1 cycles; res_carry=res_ovf=0.
- Outside ISSUE all alu_x/alu_y/alu_end/alu_carry_in are 0. Control lines are 0 in IDLE/DONE.
- DONE:
  - res_valid=1, outputs stable until res_valid&&res_ready.
  - That handshake returns to IDLE, cmd_ready=1 in the following cycle. No back-to-back accept in the same cycle.
- cmd_valid while busy is ignored (no queue).
- A new command's result never mixes with the previous one: slice results are captured only in expected capture cycles.

Optional Feature:
- Macro GF_ALU_CTRL_ZFLAG_EN.
- Defined: adds output res_zero (1 bit), high in DONE iff res_data==0. It is 0 at reset and for illegal ops, and is held with the other res_* outputs.
- Undefined: port and logic absent, all other behaviour identical.

Test Plan:
- ADD x=0x7F y=0x01 (WIDTH=8, ALU_LAT=5) -> res_data=0x80, res_ovf=1, res_carry=0; res_valid exactly 49 cycles after accept; alu_end high only on bit 7 issue.
- SUB x=0x05 y=0x07 -> res_data=0xFE, res_carry=0, res_ovf=0. RSUB x=0x05 y=0x07 -> 0x02, res_carry=1.
- AND x=0xF0 y=0x3C -> 0x30 in 14 cycles; XOR x=0xF0 y=0x3C -> 0xCC; res_carry=res_ovf=0; alu_* bits issued on 8 consecutive cycles.
- Illegal op 110 -> res_err=1, res_data=0, res_valid next cycle; no alu_* activity.
- Hold res_ready=0 for 10 cycles in DONE -> outputs stable, cmd_ready=0, cmd_valid ignored; release -> cmd_ready=1 next cycle, next ADD 0xFF+0x01 -> 0x00, carry=1, ovf=0.
- Assert rst_n=0 during WAIT of bit 3 -> all outputs reset immediately; following XOR 0xAA^0x55 -> 0xFF, unaffected by stale slice output.
